// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: arbitrates write/read requests onto a single-port RAM
// and returns read data through a credit-protected response FIFO.
// Build option: SP_RAM_CTRL_RD_PRIO_EN selects fixed read priority
// instead of round-robin arbitration.
module sp_ram_ctrl #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    grant_e                last_grant_q, last_grant_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];

    logic          push;
    logic          pop;
    logic [OW-1:0] credits_used;
    logic          wr_elig;
    logic          rd_elig;
    logic          wr_gnt;
    logic          rd_gnt;

    // Eligibility: a read needs a FIFO slot reserved for its response,
    // counting the one in flight and the slot freed by a pop this cycle.
    always_comb begin
        pop          = rsp_valid && rsp_ready;
        push         = rd_inflight_q;
        credits_used = OW'(count_q) + OW'(rd_inflight_q) - OW'(pop);
        wr_elig      = wr_valid && !rst;
        rd_elig      = rd_valid && !rst
                       && (credits_used < OW'(RSP_DEPTH));
    end

    // Arbitration: one grant per cycle between the eligible requests.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
`ifdef SP_RAM_CTRL_RD_PRIO_EN
        rd_gnt = rd_elig;
        wr_gnt = wr_elig && !rd_elig;
`else
        unique case ({wr_elig, rd_elig})
            2'b10: wr_gnt = 1'b1;
            2'b01: rd_gnt = 1'b1;
            2'b11: begin
                if (last_grant_q == GRANT_WRITE) begin
                    rd_gnt = 1'b1;
                end else begin
                    wr_gnt = 1'b1;
                end
            end
            default: ;
        endcase
`endif
    end

    // Handshake outputs and RAM port drive follow the grant directly.
    always_comb begin
        wr_ready  = wr_gnt;
        rd_ready  = rd_gnt;
        ram_wr_en = wr_gnt;
        ram_addr  = wr_gnt ? wr_addr : rd_addr;
        ram_din   = wr_data;
    end

    // Next state: grant history, read latency tracker, FIFO pointers.
    always_comb begin
        last_grant_d = last_grant_q;
        if (wr_gnt) begin
            last_grant_d = GRANT_WRITE;
        end else if (rd_gnt) begin
            last_grant_d = GRANT_READ;
        end
        rd_inflight_d = rd_gnt;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage: capture RAM output in the cycle after a read grant.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = ram_dout;
        end
    end

    // Response side: head entry is presented whenever the FIFO holds data.
    always_comb begin
        rsp_valid = (count_q != '0);
        rsp_data  = mem_q[head_q];
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q  <= GRANT_WRITE;
            rd_inflight_q <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rd_inflight_q <= rd_inflight_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Data storage needs no reset; validity is carried by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // A push into a full FIFO would mean the credit check is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == CW'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: scoreboard bench for sp_ram_ctrl with a behavioural
// registered-read RAM model attached to the RAM port.
module tb_sp_ram_ctrl;

    localparam int DW = 72;
    localparam int AW = 10;

`ifdef SP_RAM_CTRL_RD_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    sp_ram_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RSP_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .ram_wr_en(ram_wr_en),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    logic [DW-1:0] ram_mem [1024];

    always_ff @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    logic s_wr_ready, s_rd_ready, s_ram_wr_en, s_rsp_valid;
    logic s_hs_wr, s_hs_rd, s_hs_rsp;
    logic [DW-1:0] s_rsp_data;
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] exp_q [$];

    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        cyc++;
        s_wr_ready  = wr_ready;
        s_rd_ready  = rd_ready;
        s_ram_wr_en = ram_wr_en;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_hs_wr  = wr_valid && wr_ready;
        s_hs_rd  = rd_valid && rd_ready;
        s_hs_rsp = rsp_valid && rsp_ready && !rst;
        if (s_hs_wr) ref_mem[wr_addr] = wr_data;
        if (s_hs_rd) exp_q.push_back(ref_mem[rd_addr]);
        if (s_hs_rsp) begin
            rsp_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %h, required no response",
                         rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %h, required %h",
                             rsp_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic do_write(input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        int n;
        n = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        while (!s_hs_wr && n < 20) begin
            step();
            n++;
        end
        wr_valid = 1'b0;
        total++;
        if (!s_hs_wr) begin
            bad++;
            $display("FAIL wr_timeout: addr %0d got no wr_ready", a);
        end
    endtask

    task automatic drain();
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses pending, required 0",
                     exp_q.size());
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        step();
        total += 3;
        if (s_wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_wr_ready: got %b, required 0", s_wr_ready);
        end
        if (s_rd_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_rd_ready: got %b, required 0", s_rd_ready);
        end
        if (s_ram_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_ram_wr_en: got %b, required 0", s_ram_wr_en);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        total++;
        if (s_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_rsp_valid: got %b, required 0", s_rsp_valid);
        end
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 32; i++) do_write(AW'(i), rnd72());
    endtask

    task automatic test_basic();
        int c0;
        int n;
        logic [DW-1:0] pat;
        pat = {9{8'hA5}};
        do_write(AW'(5), pat);
        rd_addr  = AW'(5);
        rd_valid = 1'b1;
        n = 0;
        step();
        while (!s_hs_rd && n < 20) begin
            step();
            n++;
        end
        c0 = cyc;
        rd_valid = 1'b0;
        n = 0;
        step();
        while (!s_rsp_valid && n < 10) begin
            step();
            n++;
        end
        total += 2;
        if (cyc - c0 != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d cycles, required 2",
                     cyc - c0);
        end
        if (s_rsp_data !== pat) begin
            bad++;
            $display("FAIL basic_data: got %h, required %h",
                     s_rsp_data, pat);
        end
        drain();
    endtask

    task automatic test_alternate();
        int nw;
        int nr;
        logic exp_rd;
        nw = 0;
        nr = 0;
        apply_reset();
        wr_addr  = AW'(100);
        wr_data  = rnd72();
        rd_addr  = AW'(10);
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_rd = PRIO ? 1'b1 : (i % 2 == 0);
            total++;
            if (s_hs_rd !== exp_rd || s_hs_wr !== !exp_rd) begin
                bad++;
                $display("FAIL alt_grant%0d: got rd=%b wr=%b, required rd=%b",
                         i, s_hs_rd, s_hs_wr, exp_rd);
            end
            if (s_hs_wr) begin
                nw++;
                wr_addr = wr_addr + 1'b1;
                wr_data = rnd72();
            end
            if (s_hs_rd) begin
                nr++;
                rd_addr = rd_addr + 1'b1;
            end
        end
        total += 2;
        if (nr != (PRIO ? 8 : 4)) begin
            bad++;
            $display("FAIL alt_reads: got %0d, required %0d",
                     nr, PRIO ? 8 : 4);
        end
        if (nw != (PRIO ? 0 : 4)) begin
            bad++;
            $display("FAIL alt_writes: got %0d, required %0d",
                     nw, PRIO ? 0 : 4);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int nr;
        int r0;
        int n;
        nr = 0;
        r0 = rsp_cnt;
        rsp_ready = 1'b0;
        rd_addr   = AW'(0);
        rd_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_hs_rd) begin
                nr++;
                rd_addr = rd_addr + 1'b1;
            end
        end
        total += 2;
        if (nr != 2) begin
            bad++;
            $display("FAIL bp_accepted: got %0d reads, required 2", nr);
        end
        if (s_rd_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_rd_ready: got %b, required 0", s_rd_ready);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (nr < 4 && n < 20) begin
            step();
            if (s_hs_rd) begin
                nr++;
                rd_addr = rd_addr + 1'b1;
            end
            n++;
        end
        rd_valid = 1'b0;
        drain();
        total++;
        if (rsp_cnt - r0 != 4) begin
            bad++;
            $display("FAIL bp_responses: got %0d, required 4", rsp_cnt - r0);
        end
    endtask

    task automatic test_stream();
        int nr;
        int n;
        int bubbles;
        int first;
        nr = 0;
        n = 0;
        bubbles = 0;
        first = 0;
        rsp_ready = 1'b1;
        rd_addr   = AW'($urandom_range(0, 31));
        rd_valid  = 1'b1;
        while (nr < 100 && n < 300) begin
            step();
            n++;
            if (s_hs_rd) begin
                if (nr == 0) first = n;
                nr++;
                rd_addr = AW'($urandom_range(0, 31));
            end else if (nr > 0) begin
                bubbles++;
            end
        end
        rd_valid = 1'b0;
        total += 3;
        if (nr != 100) begin
            bad++;
            $display("FAIL stream_count: got %0d, required 100", nr);
        end
        if (bubbles != 0) begin
            bad++;
            $display("FAIL stream_bubbles: got %0d, required 0", bubbles);
        end
        if (n - first != 99) begin
            bad++;
            $display("FAIL stream_cycles: got %0d, required 99", n - first);
        end
        drain();
    endtask

    task automatic test_same_addr();
        logic [DW-1:0] old_v;
        logic [DW-1:0] new_v;
        int n;
        old_v = ref_mem[7];
        new_v = ~old_v;
        wr_addr  = AW'(7);
        wr_data  = new_v;
        rd_addr  = AW'(7);
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        step();
        total++;
        if (s_hs_wr !== !PRIO || s_hs_rd !== PRIO) begin
            bad++;
            $display("FAIL same_first: got wr=%b rd=%b, required wr=%b",
                     s_hs_wr, s_hs_rd, !PRIO);
        end
        if (s_hs_wr) wr_valid = 1'b0;
        if (s_hs_rd) rd_valid = 1'b0;
        step();
        total++;
        if (s_hs_wr !== PRIO || s_hs_rd !== !PRIO) begin
            bad++;
            $display("FAIL same_second: got wr=%b rd=%b, required wr=%b",
                     s_hs_wr, s_hs_rd, PRIO);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        n = 0;
        step();
        while (!s_rsp_valid && n < 10) begin
            step();
            n++;
        end
        total++;
        if (s_rsp_data !== (PRIO ? old_v : new_v)) begin
            bad++;
            $display("FAIL same_data: got %h, required %h",
                     s_rsp_data, PRIO ? old_v : new_v);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int nr;
        int stale;
        nr = 0;
        stale = 0;
        rsp_ready = 1'b0;
        rd_addr   = AW'(0);
        rd_valid  = 1'b1;
        step();
        if (s_hs_rd) nr++;
        rd_addr = AW'(1);
        step();
        if (s_hs_rd) nr++;
        rd_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        step();
        total += 2;
        if (nr != 2) begin
            bad++;
            $display("FAIL mid_reads: got %0d, required 2", nr);
        end
        if (s_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_buffered: got %b, required 1", s_rsp_valid);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_rsp_valid) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL mid_stale: got %0d stale cycles, required 0",
                     stale);
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_basic();
        test_alternate();
        test_backpressure();
        test_stream();
        test_same_addr();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_ctrl.md
Name: sp_ram_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port RAM (72-bit × 1024, registered read, one access per cycle).
- Accepts independent write and read request streams (valid/ready), arbitrates them onto the single RAM port, and tracks the RAM's 1-cycle read latency.
- Returns read data through a credit-protected response FIFO, so downstream backpressure never drops a read.

Parameters:
- DATA_WIDTH, 72: data word width; must match the RAM.
- ADDR_WIDTH, 10: address width; must match the RAM.
- RSP_DEPTH, 2: response FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  DATA_WIDTH  read response data.
- ram_wr_en  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_din  out  DATA_WIDTH  to RAM write data.
- ram_dout  in  DATA_WIDTH  from RAM; valid the cycle after the address is presented.

Behaviour:
- Reset (rst=1 at an edge):
  - Response FIFO emptied; rsp_valid=0; rd_inflight=0; last_grant=WRITE.
  - wr_ready, rd_ready and ram_wr_en are 0 during any cycle in which rst=1.
- Eligibility:
  - wr_elig = wr_valid.
  - rd_elig = rd_valid && (rd_inflight + fifo_count − (rsp_valid&&rsp_ready)) < RSP_DEPTH.
- Arbitration (combinational, one grant per cycle):
  - Only one eligible: that request wins.
  - Both eligible: the side that is not last_grant wins (round-robin).
  - last_grant updates on every grant.
- Ready signals:
  - wr_ready = write grant; rd_ready = read grant.
  - Ready may depend on valid; the requester must hold valid and payload until ready.
- RAM drive (combinational from the grant):
  - Write grant: ram_wr_en=1, ram_addr=wr_addr, ram_din=wr_data.
  - Read grant: ram_wr_en=0, ram_addr=rd_addr.
  - No grant: ram_wr_en=0, ram_addr=rd_addr, ram_din=wr_data.
- Read pipeline:
  - Read grant at cycle n sets rd_inflight=1 at the end of n.
  - In cycle n+1, ram_dout is pushed into the FIFO at the end of n+1.
  - rsp_valid first asserts in cycle n+2, giving a 2-cycle request-to-response latency.
  - ram_dout during write or idle cycles is ignored.
- Response FIFO:
  - Circular buffer with a log2(RSP_DEPTH)+1 bit count; pointers wrap modulo RSP_DEPTH.
  - rsp_data = head entry; rsp_valid = (count != 0).
  - Simultaneous push and pop in one cycle leaves count unchanged.
  - Overflow is impossible by construction of rd_elig. A push while full is an assertion failure.
- Ordering:
  - Responses are returned in read-grant order.
  - A read granted after a write to the same address returns the new data, because the write completes before the later read's RAM cycle.
- Throughput:
  - With rsp_ready held at 1 and only reads pending, one read is granted per cycle.
  - When both streams are valid they alternate 1:1.
- Reset mid-operation: an in-flight read and all buffered responses are discarded; none is emitted after reset.

Optional Feature:
- SP_RAM_CTRL_RD_PRIO_EN defined: fixed priority. An eligible read always beats a write; last_grant is unused; writes proceed only when no read is eligible.
- Macro undefined: round-robin as above.
- Ports and latency are identical in both builds.

Test Plan:
- Write 0xA5…A5 to addr 5, then read addr 5, with rsp_ready=1 → rsp_valid exactly 2 cycles after the read handshake, rsp_data=0xA5…A5.
- wr_valid and rd_valid held high for 8 cycles, distinct addresses → grants alternate read,write,read,… (first contention goes to read after reset); 4 of each accepted. With SP_RAM_CTRL_RD_PRIO_EN → 8 reads and 0 writes accepted.
- Reads to addr 0..3 back-to-back, rsp_ready=0 → exactly RSP_DEPTH (2) reads accepted, then rd_ready=0. Raising rsp_ready → responses for addr 0,1,2,3 delivered in order with no loss or duplication.
- 100-cycle streaming reads with rsp_ready=1 → 1 read/cycle after the first, no rd_ready bubbles, data matches a reference model.
- Same-cycle write to addr 7 and pending read to addr 7, write granted first → the read response returns the newly written value.
- Assert rst one cycle after a read grant, with one response buffered → rsp_valid=0 from the cycle after the reset edge, and no stale response appears afterwards.
